// File: rtl/riscv_types.sv
// Shared RISC-V core types: FP writeback bundle and the number of FP units
// that feed the writeback collector.
package riscv_types;

    localparam int FP_WB_UNITS = 3;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
        logic        FP_reg_write;
    } fp_wb_entry_t;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping modulo N); the pointer register is owned by the caller.
module fp_rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic found;
    int   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (enable && !found && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_wb_collector.sv
// Collects final-stage results of the pipelined FP units into per-unit slots
// and drains them round-robin into one registered writeback stream.
module fp_wb_collector
    import riscv_types::*;
#(
    parameter int N_UNITS = FP_WB_UNITS,
    parameter int XLEN    = 32,
    localparam int UW     = $clog2(N_UNITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_UNITS-1:0]      unit_valid,
    input  logic [N_UNITS*XLEN-1:0] unit_result,
    input  logic [N_UNITS*5-1:0]    unit_rd,
    input  logic [N_UNITS-1:0]      unit_reg_write,
    input  logic [N_UNITS-1:0]      unit_FP_reg_write,
    output logic [N_UNITS-1:0]      unit_en,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [XLEN-1:0]         wb_result,
    output logic [4:0]              wb_rd,
    output logic                    wb_reg_write,
    output logic                    wb_FP_reg_write,
    output logic [UW-1:0]           wb_unit
);

    logic [N_UNITS-1:0] slot_valid_q, slot_valid_d;
    fp_wb_entry_t       slot_q [N_UNITS];
    fp_wb_entry_t       slot_d [N_UNITS];
    fp_wb_entry_t       in_entry [N_UNITS];
    fp_wb_entry_t       wb_entry_q, wb_entry_d;
    logic               wb_valid_q, wb_valid_d;
    logic [UW-1:0]      wb_unit_q, wb_unit_d;
    logic [UW-1:0]      rr_ptr_q, rr_ptr_d;

    logic               load;
    logic [N_UNITS-1:0] grant;
    logic [UW-1:0]      grant_idx;
    logic [N_UNITS-1:0] capture;

    // The output register may take a new entry when empty or being consumed.
    assign load = !wb_valid_q || wb_ready;

    fp_rr_arbiter #(.N(N_UNITS)) u_arb (
        .req       (slot_valid_q),
        .ptr       (rr_ptr_q),
        .enable    (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
            assign in_entry[gi] = '{result:       unit_result[gi*XLEN +: XLEN],
                                    rd:           unit_rd[gi*5 +: 5],
                                    reg_write:    unit_reg_write[gi],
                                    FP_reg_write: unit_FP_reg_write[gi]};
            // During rst/flush the units must advance so their own clear logic runs.
            assign unit_en[gi] = rst || flush || !slot_valid_q[gi] || grant[gi];
            assign capture[gi] = unit_valid[gi] && unit_en[gi];
        end
    endgenerate

    always_comb begin
        slot_d       = slot_q;
        wb_entry_d   = wb_entry_q;
        wb_valid_d   = wb_valid_q;
        wb_unit_d    = wb_unit_q;
        rr_ptr_d     = rr_ptr_q;
        if (load) begin
            if (|grant) begin
                wb_entry_d = slot_q[grant_idx];
                wb_unit_d  = grant_idx;
                wb_valid_d = 1'b1;
                rr_ptr_d   = (grant_idx == UW'(N_UNITS - 1)) ? '0 : grant_idx + UW'(1);
            end else begin
                wb_valid_d = 1'b0;
            end
        end
        // A granted slot that captures in the same cycle stays valid with the new entry.
        slot_valid_d = (slot_valid_q & ~grant) | capture;
        for (int i = 0; i < N_UNITS; i++) begin
            if (capture[i]) begin
                slot_d[i] = in_entry[i];
            end
        end
        if (flush) begin
            slot_valid_d = '0;
            wb_valid_d   = 1'b0;
            rr_ptr_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
            wb_entry_q   <= '0;
            wb_valid_q   <= 1'b0;
            wb_unit_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            wb_entry_q   <= wb_entry_d;
            wb_valid_q   <= wb_valid_d;
            wb_unit_q    <= wb_unit_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Slot payloads are qualified by slot_valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign wb_valid        = wb_valid_q;
    assign wb_result       = wb_entry_q.result;
    assign wb_rd           = wb_entry_q.rd;
    assign wb_reg_write    = wb_entry_q.reg_write;
    assign wb_FP_reg_write = wb_entry_q.FP_reg_write;
    assign wb_unit         = wb_unit_q;

endmodule

// File: tb/tb_fp_wb_collector.sv
// Self-checking bench for fp_wb_collector: directed table, corner-case
// sequences and random traffic against a slot/queue level reference model.
module tb_fp_wb_collector;
    import riscv_types::*;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic [N-1:0]  unit_valid;
    logic [N*32-1:0] unit_result;
    logic [N*5-1:0]  unit_rd;
    logic [N-1:0]  unit_reg_write, unit_FP_reg_write;
    logic [N-1:0]  unit_en;
    logic          wb_valid, wb_ready;
    logic [31:0]   wb_result;
    logic [4:0]    wb_rd;
    logic          wb_reg_write, wb_FP_reg_write;
    logic [1:0]    wb_unit;

    fp_wb_collector #(.N_UNITS(N), .XLEN(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .unit_valid        (unit_valid),
        .unit_result       (unit_result),
        .unit_rd           (unit_rd),
        .unit_reg_write    (unit_reg_write),
        .unit_FP_reg_write (unit_FP_reg_write),
        .unit_en           (unit_en),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_result         (wb_result),
        .wb_rd             (wb_rd),
        .wb_reg_write      (wb_reg_write),
        .wb_FP_reg_write   (wb_FP_reg_write),
        .wb_unit           (wb_unit)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one pending entry per unit, one presented entry, rr pointer.
    logic         m_has [N];
    fp_wb_entry_t m_ent [N];
    logic         m_wbv;
    fp_wb_entry_t m_wb;
    int           m_unit;
    int           m_ptr;

    logic [N-1:0] obs_en;
    logic [31:0]  hs_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_unit(input int i, input logic v, input logic [31:0] r,
                            input logic [4:0] rd, input logic rw, input logic fw);
        unit_valid[i]         = v;
        unit_result[i*32 +: 32] = r;
        unit_rd[i*5 +: 5]     = rd;
        unit_reg_write[i]     = rw;
        unit_FP_reg_write[i]  = fw;
    endtask

    // One clock: check unit_en before the edge, advance the model, check wb after it.
    task automatic step();
        logic         load;
        int           g;
        logic [N-1:0] en;
        #1;
        load = !m_wbv || wb_ready;
        g = -1;
        if (load) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && m_has[j]) g = j;
            end
        end
        for (int i = 0; i < N; i++) en[i] = rst || flush || !m_has[i] || (g == i);
        obs_en = unit_en;
        chk("unit_en", 64'(unit_en), 64'(en));
        if (wb_valid && wb_ready && !rst && !flush) begin
            $display("wb accept: unit %0d result %08h rd %0d rw %0b fw %0b",
                     wb_unit, wb_result, wb_rd, wb_reg_write, wb_FP_reg_write);
            hs_q.push_back(wb_result);
        end
        if (rst) begin
            for (int i = 0; i < N; i++) m_has[i] = 1'b0;
            m_wbv = 1'b0; m_wb = '0; m_unit = 0; m_ptr = 0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_has[i] = 1'b0;
            m_wbv = 1'b0; m_ptr = 0;
        end else begin
            if (load) begin
                if (g >= 0) begin
                    m_wb = m_ent[g]; m_has[g] = 1'b0;
                    m_unit = g; m_wbv = 1'b1; m_ptr = (g + 1) % N;
                end else begin
                    m_wbv = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (unit_valid[i] && en[i]) begin
                    m_has[i] = 1'b1;
                    m_ent[i] = '{result: unit_result[i*32 +: 32], rd: unit_rd[i*5 +: 5],
                                 reg_write: unit_reg_write[i], FP_reg_write: unit_FP_reg_write[i]};
                end
            end
        end
        @(posedge clk);
        #1;
        chk("wb_valid", 64'(wb_valid), 64'(m_wbv));
        if (m_wbv)
            chk("wb_payload", 64'({wb_result, wb_rd, wb_reg_write, wb_FP_reg_write, wb_unit}),
                64'({m_wb.result, m_wb.rd, m_wb.reg_write, m_wb.FP_reg_write, 2'(m_unit)}));
        @(negedge clk);
    endtask

    task automatic idle_units();
        for (int i = 0; i < N; i++) set_unit(i, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [31:0] r0, r1, r2;
        logic        rdy, fl;
        logic [2:0]  en;
        logic        wbv;
        logic [1:0]  u;
        logic [31:0] res;
    } vec_t;

    vec_t tbl [16];

    logic         src_v [N];
    logic [31:0]  src_r [N];
    logic [4:0]   src_rd [N];
    logic         src_rw [N], src_fw [N];

    initial begin
        // single result, flush, all-three burst, fairness between units 0 and 2
        tbl[0]  = '{3'b001, 32'h3F800000, 32'h0, 32'h0,        1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 32'h0};
        tbl[1]  = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b0, 3'b111, 1'b1, 2'd0, 32'h3F800000};
        tbl[2]  = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 32'h0};
        tbl[3]  = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b1, 3'b111, 1'b0, 2'd0, 32'h0};
        tbl[4]  = '{3'b111, 32'h40000000, 32'h40400000, 32'h40800000, 1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 32'h0};
        tbl[5]  = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b0, 3'b001, 1'b1, 2'd0, 32'h40000000};
        tbl[6]  = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b0, 3'b011, 1'b1, 2'd1, 32'h40400000};
        tbl[7]  = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b0, 3'b111, 1'b1, 2'd2, 32'h40800000};
        tbl[8]  = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 32'h0};
        tbl[9]  = '{3'b101, 32'h10000001, 32'h0, 32'h30000001, 1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 32'h0};
        tbl[10] = '{3'b101, 32'h10000002, 32'h0, 32'h30000002, 1'b1, 1'b0, 3'b011, 1'b1, 2'd0, 32'h10000001};
        tbl[11] = '{3'b101, 32'h10000003, 32'h0, 32'h30000002, 1'b1, 1'b0, 3'b110, 1'b1, 2'd2, 32'h30000001};
        tbl[12] = '{3'b101, 32'h10000003, 32'h0, 32'h30000003, 1'b1, 1'b0, 3'b011, 1'b1, 2'd0, 32'h10000002};
        tbl[13] = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b0, 3'b110, 1'b1, 2'd2, 32'h30000002};
        tbl[14] = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b0, 3'b111, 1'b1, 2'd0, 32'h10000003};
        tbl[15] = '{3'b000, 32'h0, 32'h0, 32'h0,               1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 32'h0};

        for (int i = 0; i < N; i++) begin m_has[i] = 1'b0; m_ent[i] = '0; end
        m_wbv = 1'b0; m_wb = '0; m_unit = 0; m_ptr = 0;
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
        unit_valid = '0; unit_result = '0; unit_rd = '0;
        unit_reg_write = '0; unit_FP_reg_write = '0;

        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("reset_outputs", 64'({wb_valid, wb_result, wb_rd, wb_reg_write, wb_FP_reg_write, wb_unit}), 64'h0);

        // Directed table
        for (int t = 0; t < 16; t++) begin
            set_unit(0, tbl[t].v[0], tbl[t].r0, 5'd5, 1'b0, 1'b1);
            set_unit(1, tbl[t].v[1], tbl[t].r1, 5'd6, 1'b0, 1'b1);
            set_unit(2, tbl[t].v[2], tbl[t].r2, 5'd7, 1'b0, 1'b1);
            wb_ready = tbl[t].rdy;
            flush    = tbl[t].fl;
            step();
            chk($sformatf("tbl%0d_en", t), 64'(obs_en), 64'(tbl[t].en));
            chk($sformatf("tbl%0d_wbv", t), 64'(wb_valid), 64'(tbl[t].wbv));
            if (tbl[t].wbv)
                chk($sformatf("tbl%0d_unit_res", t), 64'({wb_unit, wb_result}), 64'({tbl[t].u, tbl[t].res}));
        end
        flush = 1'b0;
        idle_units();

        // Backpressure: unit 1 issues back-to-back while wb_ready is low for 5 cycles
        begin
            int cur;
            cur = 1;
            hs_q.delete();
            for (int c = 0; c < 14; c++) begin
                set_unit(1, cur <= 4, 32'h50000000 + 32'(cur), 5'd9, 1'b1, 1'b0);
                wb_ready = !(c >= 2 && c <= 6);
                step();
                if (c >= 2 && c <= 6) begin
                    chk("bp_hold_payload", 64'({wb_valid, wb_result, wb_unit}), 64'({1'b1, 32'h50000001, 2'd1}));
                    chk("bp_en1_low", 64'(obs_en[1]), 64'h0);
                end
                if (cur <= 4 && obs_en[1]) cur++;
            end
            chk("bp_count", 64'(hs_q.size()), 64'd4);
            for (int k = 0; k < 4; k++)
                if (k < hs_q.size()) chk("bp_order", 64'(hs_q[k]), 64'(32'h50000001 + 32'(k)));
        end
        idle_units();
        wb_ready = 1'b1;
        step();

        // Flush mid-stall: two slots full, wb presented and stalled
        wb_ready = 1'b0;
        set_unit(0, 1'b1, 32'h61000000, 5'd1, 1'b0, 1'b1);
        set_unit(1, 1'b1, 32'h62000000, 5'd2, 1'b0, 1'b1);
        step();
        idle_units();
        set_unit(2, 1'b1, 32'h63000000, 5'd3, 1'b0, 1'b1);
        step();
        chk("fl_pre_wbv", 64'(wb_valid), 64'h1);
        idle_units();
        set_unit(0, 1'b1, 32'h64000000, 5'd4, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_wbv_cleared", 64'(wb_valid), 64'h0);
        idle_units();
        set_unit(1, 1'b1, 32'h77777777, 5'd17, 1'b1, 1'b0);
        wb_ready = 1'b1;
        step();
        chk("fl_en_all_ones", 64'(obs_en), 64'h7);
        chk("fl_no_early_wb", 64'(wb_valid), 64'h0);
        idle_units();
        step();
        chk("fl_new_result", 64'({wb_valid, wb_unit, wb_result}), 64'({1'b1, 2'd1, 32'h77777777}));
        step();

        // Reset mid-operation
        wb_ready = 1'b0;
        for (int i = 0; i < N; i++) set_unit(i, 1'b1, 32'h81000000 + 32'(i), 5'(i + 20), 1'b1, 1'b1);
        step();
        for (int i = 0; i < N; i++) set_unit(i, 1'b1, 32'h82000000 + 32'(i), 5'(i + 24), 1'b1, 1'b1);
        step();
        for (int i = 0; i < N; i++) set_unit(i, 1'b1, 32'h83000000 + 32'(i), 5'(i + 28), 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_outputs", 64'({wb_valid, wb_result, wb_rd, wb_reg_write, wb_FP_reg_write, wb_unit}), 64'h0);
        chk("rst_mid_en", 64'(obs_en), 64'h7);
        idle_units();
        wb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_no_stale", 64'(wb_valid), 64'h0);
        end

        // Random traffic against the model
        for (int i = 0; i < N; i++) src_v[i] = 1'b0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_v[i] && $urandom_range(0, 1) == 1) begin
                    src_v[i]  = 1'b1;
                    src_r[i]  = $urandom;
                    src_rd[i] = 5'($urandom_range(0, 31));
                    src_rw[i] = 1'($urandom_range(0, 1));
                    src_fw[i] = 1'($urandom_range(0, 1));
                end
                set_unit(i, src_v[i], src_r[i], src_rd[i], src_rw[i], src_fw[i]);
            end
            wb_ready = ($urandom_range(0, 99) < 70);
            flush    = ($urandom_range(0, 99) < 3);
            step();
            for (int i = 0; i < N; i++)
                if (flush || (src_v[i] && obs_en[i])) src_v[i] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
